// File: rtl/ws2812_bit_driver.sv
// rtl/ws2812_bit_driver.sv - WS2812 NRZ serialiser, final stage of the LED path
//
// Takes 24-bit colour words from the serial-bus translator and drives them
// MSB-first onto the WS2812 data line using pulse-width bit timing. Each frame
// ends with a low latch period.
//
// Ports:
//   clk_sb          system clock, shared with the translator
//   reset           synchronous, active-high
//   rgb_data_in     colour word; bit 23 goes out first
//   send_leds_n     active-low frame enable, held low while words remain
//   ws2812_next_led one-cycle request for the next word
//   ws2812_dout     serial line to the LED strip
//   busy            high whenever the driver is not idle
module ws2812_bit_driver #(
  parameter int T_BIT     = 60,
  parameter int T0H       = 19,
  parameter int T1H       = 38,
  parameter int T_RESET   = 2400,
  parameter int LOAD_WAIT = 4
) (
  input  logic        clk_sb,
  input  logic        reset,
  input  logic [23:0] rgb_data_in,
  input  logic        send_leds_n,
  output logic        ws2812_next_led,
  output logic        ws2812_dout,
  output logic        busy
);

  localparam logic [15:0] BIT_LAST   = 16'(T_BIT - 1);
  localparam logic [15:0] LATCH_LAST = 16'(T_RESET - 1);
  localparam logic [15:0] LOAD_LAST  = 16'(LOAD_WAIT - 1);
  localparam logic [15:0] T0H_W      = 16'(T0H);
  localparam logic [15:0] T1H_W      = 16'(T1H);

  typedef enum logic [1:0] {IDLE, FETCH, BIT, LATCH} state_t;

  state_t      state, state_n;
  logic [15:0] timer, timer_n;
  logic [4:0]  bit_idx, bit_idx_n;
  logic [23:0] shreg, shreg_n;
  logic        pend, pend_n;
  logic        next_led_n, dout_n, busy_n;

  always_ff @(posedge clk_sb) begin
    if (reset) begin
      state           <= IDLE;
      timer           <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      pend            <= 1'b0;
      ws2812_next_led <= 1'b0;
      ws2812_dout     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_n;
      timer           <= timer_n;
      bit_idx         <= bit_idx_n;
      shreg           <= shreg_n;
      pend            <= pend_n;
      ws2812_next_led <= next_led_n;
      ws2812_dout     <= dout_n;
      busy            <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    pend_n     = pend;
    next_led_n = 1'b0;

    case (state)
      IDLE: begin
        timer_n = '0;
        pend_n  = 1'b0;
        if (!send_leds_n) begin
          next_led_n = 1'b1;
          state_n    = FETCH;
        end
      end

      // Give the translator LOAD_WAIT cycles to present the requested word.
      FETCH: begin
        if (timer == LOAD_LAST) begin
          shreg_n   = rgb_data_in;
          bit_idx_n = 5'd23;
          timer_n   = '0;
          state_n   = BIT;
        end else begin
          timer_n = timer + 16'd1;
        end
      end

      BIT: begin
        // Request the following word a whole bit period ahead so it can be
        // loaded without stretching the last bit of this word.
        if (bit_idx == 5'd0 && timer == 16'd0) begin
          next_led_n = !send_leds_n;
          pend_n     = !send_leds_n;
        end
        if (timer == BIT_LAST) begin
          timer_n = '0;
          if (bit_idx != 5'd0) begin
            shreg_n   = {shreg[22:0], 1'b0};
            bit_idx_n = bit_idx - 5'd1;
          end else if (pend) begin
            shreg_n   = rgb_data_in;
            bit_idx_n = 5'd23;
            pend_n    = 1'b0;
          end else begin
            state_n = LATCH;
          end
        end else begin
          timer_n = timer + 16'd1;
        end
      end

      LATCH: begin
        if (timer == LATCH_LAST) begin
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 16'd1;
        end
      end

      default: state_n = IDLE;
    endcase

    // Outputs are computed from next-state values so the registered line
    // lines up with the state/timer it belongs to.
    dout_n = (state_n == BIT) && (timer_n < (shreg_n[23] ? T1H_W : T0H_W));
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_ws2812_bit_driver.sv
// tb/tb_ws2812_bit_driver.sv - scoreboard bench for ws2812_bit_driver
module tb_ws2812_bit_driver;

  localparam int TB = 10;
  localparam int T0 = 3;
  localparam int T1 = 7;
  localparam int TR = 40;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] rgb;
  logic        send_n;
  logic        next_led, dout, busy;
  logic [23:0] rgb2;
  logic        send_n2;
  logic        next2, dout2, busy2;

  always #5 clk = ~clk;

  ws2812_bit_driver #(.T_BIT(TB), .T0H(T0), .T1H(T1), .T_RESET(TR), .LOAD_WAIT(LW)) dut (
    .clk_sb(clk), .reset(reset), .rgb_data_in(rgb), .send_leds_n(send_n),
    .ws2812_next_led(next_led), .ws2812_dout(dout), .busy(busy)
  );

  ws2812_bit_driver #(.T_BIT(60), .T0H(19), .T1H(38), .T_RESET(2400), .LOAD_WAIT(4)) dut2 (
    .clk_sb(clk), .reset(reset), .rgb_data_in(rgb2), .send_leds_n(send_n2),
    .ws2812_next_led(next2), .ws2812_dout(dout2), .busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Scoreboard queues: high width per bit, rise count at each pulse, latch low run.
  int exp_bits[$];
  int exp_pulse[$];
  int exp_latch[$];
  logic [23:0] frame_words[$];

  bit   mon_en = 1'b1;
  int   cyc = 0, frame_rises = 0, rise_t = 0, low_run = 0;
  logic prev_dout = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!mon_en) begin
      frame_rises = 0;
      low_run     = 0;
      prev_dout   = 1'b0;
      prev_busy   = 1'b0;
    end else begin
      if (busy === 1'b0) frame_rises = 0;
      if (dout === 1'b1 && prev_dout === 1'b0) begin
        if (frame_rises > 0) check("bit_period", cyc - rise_t, TB);
        rise_t = cyc;
        frame_rises++;
        low_run = 0;
      end
      if (dout === 1'b0 && prev_dout === 1'b1) begin
        if (exp_bits.size() == 0) fail_now("unexpected_bit");
        else check("high_width", cyc - rise_t, exp_bits.pop_front());
      end
      if (next_led === 1'b1) begin
        if (exp_pulse.size() == 0) fail_now("unexpected_pulse");
        else check("pulse_pos", frame_rises, exp_pulse.pop_front());
      end
      if (busy === 1'b1 && dout === 1'b0) low_run++;
      if (busy === 1'b0 && prev_busy === 1'b1) begin
        if (exp_latch.size() == 0) fail_now("unexpected_latch");
        else check("latch_low", low_run, exp_latch.pop_front());
        low_run = 0;
      end
      prev_dout = dout;
      prev_busy = busy;
    end
  end

  task automatic push_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) exp_bits.push_back(w[i] ? T1 : T0);
  endtask

  // Translator model: present the next word one cycle after each request.
  task automatic load_next();
    @(posedge clk);
    #1;
    rgb = frame_words.pop_front();
    if (frame_words.size() == 0) send_n = 1'b1;
  endtask

  task automatic run_frame(input bit pulsed);
    int guard = 0;
    send_n = 1'b0;
    if (pulsed) load_next();
    while (frame_words.size() > 0) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        fail_now("frame_timeout");
        frame_words.delete();
        send_n = 1'b1;
      end else if (next_led === 1'b1) begin
        load_next();
      end
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (busy !== 1'b0 && guard < 1500);
    if (busy !== 1'b0) fail_now("idle_timeout");
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int latch_entry, guard, r, pulses, highs, cur;
    logic prevd, lvl;
    bit started;
    int runs[$];

    reset = 1'b1; send_n = 1'b0; rgb = '0;
    send_n2 = 1'b1; rgb2 = '0;

    // Reset with the frame enable already low, then the single-word frame.
    exp_pulse.push_back(0);
    push_word(24'hA50F81);
    exp_latch.push_back(43);
    frame_words.push_back(24'hA50F81);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_dout", int'(dout), 0);
      check("reset_next_led", int'(next_led), 0);
      check("reset_busy", int'(busy), 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("pulse_after_reset", int'(next_led), 1);
    run_frame(1);
    wait_idle();

    // Three back-to-back words.
    exp_pulse.push_back(0); exp_pulse.push_back(24); exp_pulse.push_back(48);
    push_word(24'hFF0000); push_word(24'h00FF00); push_word(24'h0000FF);
    exp_latch.push_back(43);
    frame_words.push_back(24'hFF0000);
    frame_words.push_back(24'h00FF00);
    frame_words.push_back(24'h0000FF);
    run_frame(0);
    wait_idle();

    // All-ones word, enable held low during latch, then an all-zeros frame.
    exp_pulse.push_back(0); push_word(24'hFFFFFF); exp_latch.push_back(43);
    exp_pulse.push_back(0); push_word(24'h000000); exp_latch.push_back(47);
    frame_words.push_back(24'hFFFFFF);
    run_frame(0);
    guard = 0;
    while (frame_rises != 24 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    if (frame_rises != 24) fail_now("last_bit_timeout");
    latch_entry = rise_t + TB;
    while (cyc < latch_entry + 1) @(posedge clk);
    #1 send_n = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (next_led !== 1'b1 && guard < 200);
    check("latch_restart", cyc - latch_entry, TR + 1);
    frame_words.push_back(24'h000000);
    run_frame(1);
    wait_idle();

    // Reset in the middle of bit 12.
    mon_en = 1'b0;
    send_n = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (next_led !== 1'b1 && guard < 50);
    @(posedge clk);
    #1 rgb = 24'h5A5A5A; send_n = 1'b1;
    r = 0; prevd = 1'b0; guard = 0;
    while (r < 12 && guard < 500) begin
      @(negedge clk);
      guard++;
      if (dout === 1'b1 && prevd === 1'b0) r++;
      prevd = dout;
    end
    check("reached_bit12", r, 12);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midword_reset_dout", int'(dout), 0);
    check("midword_reset_busy", int'(busy), 0);
    check("midword_reset_next", int'(next_led), 0);
    reset = 1'b0;
    pulses = 0; highs = 0;
    repeat (30) begin
      @(negedge clk);
      if (next_led !== 1'b0) pulses++;
      if (dout !== 1'b0 || busy !== 1'b0) highs++;
    end
    check("no_pulse_after_reset", pulses, 0);
    check("quiet_after_reset", highs, 0);
    mon_en = 1'b1;

    // Full-size timing: word 400000 gives a '0' bit then a '1' bit first.
    rgb2 = 24'h400000;
    send_n2 = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (next2 !== 1'b1 && guard < 20);
    check("timing_pulse", int'(next2), 1);
    @(posedge clk);
    #1 send_n2 = 1'b1;
    started = 1'b0; cur = 0; lvl = 1'b0; guard = 0;
    while (guard < 6000) begin
      @(negedge clk);
      guard++;
      if (!started) begin
        if (dout2 === 1'b1) begin started = 1'b1; lvl = 1'b1; cur = 1; end
      end else if (busy2 !== 1'b1) begin
        runs.push_back(cur);
        break;
      end else if (dout2 === lvl) begin
        cur++;
      end else begin
        runs.push_back(cur);
        lvl = dout2;
        cur = 1;
      end
    end
    check("timing_runs", runs.size(), 48);
    if (runs.size() == 48) begin
      check("t0_high", runs[0], 19);
      check("t0_low", runs[1], 41);
      check("t1_high", runs[2], 38);
      check("t1_low", runs[3], 22);
      check("t_last_high", runs[46], 19);
      check("t_latch_low", runs[47], 41 + 2400);
    end

    check("bits_left", exp_bits.size(), 0);
    check("pulses_left", exp_pulse.size(), 0);
    check("latches_left", exp_latch.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
